video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Parametrised video timing and test-pattern generator for the HDMI/DVI output path. Successor to the fixed 1080p colour-bar source.
- Timing is set entirely by parameters. Sync polarities are selectable.
- Four runtime-selectable patterns, with optional horizontal scrolling.
- Drives the transmitter front end directly, or acts as a fallback/overlay source when the camera stream is absent.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (clocks)
H_SYNC, 44, horizontal sync width (clocks)
H_BP, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hs asserted level (1 = active-high)
VS_POL, 1, vs asserted level
GRID, 64, grid pitch in pixels/lines for mode 2, >=2
CW, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
mode  in  2  pattern select: 0 bars, 1 gradient, 2 grid, 3 solid
scroll_en  in  1  enables per-frame horizontal scroll of modes 0/1
solid_rgb  in  24  {R,G,B} colour for mode 3
hs  out  1  horizontal sync, level per HS_POL
vs  out  1  vertical sync, level per VS_POL
de  out  1  data enable, high in active area
rgb_r  out  8  red
rgb_g  out  8  green
rgb_b  out  8  blue
x  out  CW  active pixel x (valid when de)
y  out  CW  active line y (valid when de)
sof  out  1  one-clock pulse coincident with first de of a frame
frame_cnt  out  16  frames started since reset, wraps at 65535->0

Behaviour:
- Reset values: clk is specified as above; rst is asynchronous, active-high. While rst is asserted:
  - h_cnt = v_cnt = 0, frame_cnt = 0.
  - hs = ~HS_POL, vs = ~VS_POL.
  - de = 0, sof = 0, rgb = 0, x = y = 0.
  - The latched mode register resets to 0.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h_cnt counts 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 and wraps.
- Region order per line: active [0,H_ACTIVE), FP, SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP. Vertical uses the same order in lines.
- hs asserted for h_cnt in the sync range. vs asserted for the whole lines with v_cnt in the vertical sync range; vs edges coincide with h_cnt = 0.
- Output latency: every output is registered and reflects the counter state of the previous clock, so all outputs are mutually aligned.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x = h_cnt, y = v_cnt while de; both hold their last value otherwise.
  - rgb = 0 whenever de = 0.
- Frame start is h_cnt = 0 and v_cnt = 0. At frame start:
  - mode and scroll_en are latched; they never change mid-frame.
  - frame_cnt increments.
  - The sof output pulses with the first de.
  - The first frame after reset has frame_cnt = 1 on its sof.
- Scroll offset:
  - off = frame_cnt[CW-1:0] * 4, taken modulo H_ACTIVE using a running offset register that adds 4 each frame and subtracts H_ACTIVE on overflow.
  - off is 0 when the latched scroll_en = 0.
  - xs = x + off, minus H_ACTIVE if the sum is >= H_ACTIVE.
- Mode 0, colour bars:
  - BW = H_ACTIVE/8. Bar index = min(xs/BW, 7); any remainder pixels belong to bar 7.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Colour components are 8'hFF or 8'h00.
  - The division is implemented as a bar counter plus a within-bar counter, not a divider.
- Mode 1, gradient: R = G = B = xs[7:0], so the ramp repeats every 256 pixels.
- Mode 2, grid:
  - White (FF,FF,FF) when (x mod GRID == 0) or (y mod GRID == 0); black otherwise.
  - Modulo is computed with column/row sub-counters that reset at the start of each line/frame.
- Mode 3, solid: rgb = solid_rgb sampled every clock (not latched).
- Reset mid-frame: outputs return to reset values immediately (asynchronous). On release, timing restarts at h_cnt = 0, v_cnt = 0, which is a frame start.
- Parameter sanity: GRID < 2 or H_ACTIVE < 8 is unsupported.

Test Plan:
- Small timing H=16/2/3/4, V=8/1/2/3, mode 0, 3 frames:
  - hs period 25 clocks, low 3.
  - vs low exactly 2 lines.
  - 128 de clocks per frame.
  - sof once per frame; frame_cnt reads 1, 2, 3.
- Mode 0 at 1920 wide:
  - x = 0..239 is white, x = 240 yellow, x = 1679 blue, x = 1680..1919 black.
  - Transitions occur exactly on the same cycle as x changes.
- Mode 2 with GRID = 4 on the 16x8 frame:
  - White where x ∈ {0,4,8,12} or y ∈ {0,4}; all other active pixels black.
- scroll_en = 1, mode 0, H_ACTIVE = 16 (BW = 2): frame 2 shows at x = 0 the colour of bar (8/2)=4 (magenta); offset wraps cleanly past 16.
- mode changed from 0 to 3 mid-frame: current frame stays bars; the next sof frame is all solid_rgb = 24'h123456.
- rst asserted mid-line, then released:
  - Outputs are at reset values during rst.
  - The first de occurs 1 clock after release.
  - sof asserts with it and frame_cnt = 1.
  - hs/vs polarity honoured with HS_POL = VS_POL = 0.

Source files
------------

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
//   Parametrised video timing and test-pattern generator. Timing comes entirely
//   from parameters. Four runtime patterns: colour bars, grey gradient, grid and
//   solid colour. Bars and gradient can scroll horizontally by 4 pixels/frame.
//
// Ports
//   clk        in   pixel clock
//   rst        in   asynchronous, active-high reset
//   mode       in   pattern: 0 bars, 1 gradient, 2 grid, 3 solid (latched per frame)
//   scroll_en  in   per-frame horizontal scroll of modes 0/1 (latched per frame)
//   solid_rgb  in   {R,G,B} for mode 3, used live every clock
//   hs, vs     out  syncs, asserted level set by HS_POL / VS_POL
//   de         out  data enable, high in the active area
//   rgb_r/g/b  out  pixel colour, zero outside the active area
//   x, y       out  active pixel coordinates, hold their value while de = 0
//   sof        out  one-clock pulse with the first de of a frame
//   frame_cnt  out  frames started since reset (wraps)
//
// All outputs are registered from the counter state of the previous clock, so
// they are mutually aligned. GRID >= 2, H_ACTIVE >= 8 and CW >= 8 are assumed.
// -----------------------------------------------------------------------------
module video_pattern_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int GRID     = 64,
   parameter int CW       = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode,
   input  logic          scroll_en,
   input  logic [23:0]   solid_rgb,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [7:0]    rgb_r,
   output logic [7:0]    rgb_g,
   output logic [7:0]    rgb_b,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          sof,
   output logic [15:0]   frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] X_LAST    = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] BW_LAST   = CW'(H_ACTIVE / 8 - 1);
   localparam logic [CW-1:0] GRID_LAST = CW'(GRID - 1);
   localparam logic          HS_ON     = (HS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic          VS_ON     = (VS_POL != 0) ? 1'b1 : 1'b0;

   // Scrolled horizontal position kept in three forms at once: the raw
   // coordinate (gradient), the bar index and the offset inside that bar.
   // Stepping all three together replaces a divide by the bar width.
   typedef struct packed {
      logic [CW-1:0] xs;
      logic [2:0]    bar;
      logic [CW-1:0] rem;
   } pos_t;

   localparam pos_t POS_ZERO = '{xs: {CW{1'b0}}, bar: 3'd0, rem: {CW{1'b0}}};

   // Advance a scrolled position by one pixel, wrapping at H_ACTIVE.
   // Bar 7 never advances, so leftover pixels of H_ACTIVE/8 land in it.
   function automatic pos_t pos_step(input pos_t p);
      pos_t n;
      n = p;
      if (p.xs == X_LAST) begin
         n = POS_ZERO;
      end else begin
         n.xs = p.xs + ONE;
         if ((p.bar != 3'd7) && (p.rem == BW_LAST)) begin
            n.bar = p.bar + 3'd1;
            n.rem = ZERO;
         end else begin
            n.rem = p.rem + ONE;
         end
      end
      return n;
   endfunction

   // Bar colour table: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] bar_colour(input logic [2:0] bar);
      logic [23:0] c;
      case (bar)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   logic [CW-1:0] h_cnt_r, v_cnt_r;
   logic [1:0]    mode_r;
   logic          scroll_r;
   pos_t          run_r;      // running offset: frame_cnt*4 mod H_ACTIVE
   pos_t          cur_r;      // scrolled position of the previous pixel
   logic [CW-1:0] gx_r, gy_r; // grid column / row sub-counters

   logic [CW-1:0] h_next_s, v_next_s, gx_s, gy_s;
   logic          frame_start_s, line_start_s, active_s, hs_s, vs_s;
   logic [1:0]    mode_s;
   logic          scroll_s;
   pos_t          run_next_s, cur_s;
   logic [23:0]   pix_s, rgb_s;

   // Next-counter values, per-frame latching and the pixel colour for the
   // current counter position.
   always_comb begin
      h_next_s      = ZERO;
      v_next_s      = v_cnt_r;
      frame_start_s = (h_cnt_r == ZERO) && (v_cnt_r == ZERO);
      line_start_s  = (h_cnt_r == ZERO);
      active_s      = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
      mode_s        = mode_r;
      scroll_s      = scroll_r;
      run_next_s    = run_r;
      cur_s         = POS_ZERO;
      gx_s          = ZERO;
      gy_s          = gy_r;
      pix_s         = 24'h000000;
      rgb_s         = 24'h000000;
      hs_s          = ~HS_ON;
      vs_s          = ~VS_ON;

      if (h_cnt_r == H_LAST) begin
         h_next_s = ZERO;
         if (v_cnt_r == V_LAST) begin
            v_next_s = ZERO;
         end else begin
            v_next_s = v_cnt_r + ONE;
         end
      end else begin
         h_next_s = h_cnt_r + ONE;
         v_next_s = v_cnt_r;
      end

      // The first pixel of a frame already uses the freshly latched controls
      // and the advanced scroll offset.
      if (frame_start_s) begin
         mode_s     = mode;
         scroll_s   = scroll_en;
         run_next_s = pos_step(pos_step(pos_step(pos_step(run_r))));
      end else begin
         mode_s     = mode_r;
         scroll_s   = scroll_r;
         run_next_s = run_r;
      end

      if (line_start_s) begin
         if (scroll_s) begin
            cur_s = run_next_s;
         end else begin
            cur_s = POS_ZERO;
         end
         gx_s = ZERO;
         if (frame_start_s) begin
            gy_s = ZERO;
         end else if (gy_r == GRID_LAST) begin
            gy_s = ZERO;
         end else begin
            gy_s = gy_r + ONE;
         end
      end else begin
         cur_s = pos_step(cur_r);
         gy_s  = gy_r;
         if (gx_r == GRID_LAST) begin
            gx_s = ZERO;
         end else begin
            gx_s = gx_r + ONE;
         end
      end

      case (mode_s)
         2'd0:    pix_s = bar_colour(cur_s.bar);
         2'd1:    pix_s = {cur_s.xs[7:0], cur_s.xs[7:0], cur_s.xs[7:0]};
         2'd2:    pix_s = ((gx_s == ZERO) || (gy_s == ZERO)) ? 24'hFFFFFF : 24'h000000;
         2'd3:    pix_s = solid_rgb;
         default: pix_s = 24'h000000;
      endcase

      if (active_s) begin
         rgb_s = pix_s;
      end else begin
         rgb_s = 24'h000000;
      end

      if ((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END)) begin
         hs_s = HS_ON;
      end else begin
         hs_s = ~HS_ON;
      end

      if ((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END)) begin
         vs_s = VS_ON;
      end else begin
         vs_s = ~VS_ON;
      end
   end

   // Counters, per-frame state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_r   <= ZERO;
         v_cnt_r   <= ZERO;
         mode_r    <= 2'd0;
         scroll_r  <= 1'b0;
         run_r     <= POS_ZERO;
         cur_r     <= POS_ZERO;
         gx_r      <= ZERO;
         gy_r      <= ZERO;
         hs        <= ~HS_ON;
         vs        <= ~VS_ON;
         de        <= 1'b0;
         sof       <= 1'b0;
         rgb_r     <= 8'h00;
         rgb_g     <= 8'h00;
         rgb_b     <= 8'h00;
         x         <= ZERO;
         y         <= ZERO;
         frame_cnt <= 16'd0;
      end else begin
         h_cnt_r  <= h_next_s;
         v_cnt_r  <= v_next_s;
         mode_r   <= mode_s;
         scroll_r <= scroll_s;
         run_r    <= run_next_s;
         cur_r    <= cur_s;
         gx_r     <= gx_s;
         gy_r     <= gy_s;
         hs       <= hs_s;
         vs       <= vs_s;
         de       <= active_s;
         sof      <= frame_start_s;
         rgb_r    <= rgb_s[23:16];
         rgb_g    <= rgb_s[15:8];
         rgb_b    <= rgb_s[7:0];
         if (active_s) begin
            x <= h_cnt_r;
            y <= v_cnt_r;
         end else begin
            x <= x;
            y <= y;
         end
         if (frame_start_s) begin
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            frame_cnt <= frame_cnt;
         end
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
//   dut_a: 16x8 active, H 16/2/3/4, V 8/1/2/3, GRID 4, negative syncs.
//   dut_b: default 1920x1080 timing, only its first line is examined.
//   Stimulus pushes expected pixels into queues; negedge monitors pop and
//   compare whenever de is high.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [1:0]  mode_a, mode_b;
   logic        scroll_a, scroll_b;
   logic [23:0] solid_a, solid_b;

   logic        hs_a, vs_a, de_a, sof_a;
   logic [7:0]  r_a, g_a, b_a;
   logic [7:0]  x_a, y_a;
   logic [15:0] fc_a;

   logic        hs_b, vs_b, de_b, sof_b;
   logic [7:0]  r_b, g_b, b_b;
   logic [11:0] x_b, y_b;
   logic [15:0] fc_b;

   video_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
      .HS_POL(0), .VS_POL(0), .GRID(4), .CW(8)
   ) dut_a (
      .clk(clk), .rst(rst_a), .mode(mode_a), .scroll_en(scroll_a),
      .solid_rgb(solid_a), .hs(hs_a), .vs(vs_a), .de(de_a),
      .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a), .x(x_a), .y(y_a),
      .sof(sof_a), .frame_cnt(fc_a)
   );

   video_pattern_gen dut_b (
      .clk(clk), .rst(rst_b), .mode(mode_b), .scroll_en(scroll_b),
      .solid_rgb(solid_b), .hs(hs_b), .vs(vs_b), .de(de_b),
      .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b), .x(x_b), .y(y_b),
      .sof(sof_b), .frame_cnt(fc_b)
   );

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [23:0] rgb;
      logic        sof;
      logic [15:0] fc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   errors = 0;
   int   checks = 0;

   // timing-measurement state for dut_a
   logic tim_en = 1'b0;
   logic hs_prev = 1'b1, vs_prev = 1'b1;
   int   cyc_a = 0, hs_fall = 0, vs_fall = 0, de_cnt = 0;
   bit   hs_seen = 1'b0, vs_seen = 1'b0, sof_seen = 1'b0;
   logic [7:0] last_x = 8'd0, last_y = 8'd0;
   exp_t ea, aa, eb, ab;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [23:0] bar_col(input int b);
      case (b)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected colour; grid pitch 4 applies to dut_a only.
   function automatic logic [23:0] exp_rgb(input int md, input int w, input int x,
                                           input int y, input int off, input logic [23:0] solid);
      int xs, b;
      logic [7:0] g;
      xs = (x + off) % w;
      b  = xs / (w / 8);
      if (b > 7) b = 7;
      g = 8'(xs);
      case (md)
         0: return bar_col(b);
         1: return {g, g, g};
         2: return ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
         default: return solid;
      endcase
   endfunction

   task automatic push_frame_a(input int f, input int md, input bit sc, input int npix);
      exp_t e;
      int   off;
      off = sc ? (f * 4) % 16 : 0;
      for (int n = 0; n < npix; n++) begin
         e.x   = 12'(n % 16);
         e.y   = 12'(n / 16);
         e.rgb = exp_rgb(md, 16, n % 16, n / 16, off, solid_a);
         e.sof = (n == 0);
         e.fc  = 16'(f);
         qa.push_back(e);
      end
   endtask

   // Called one tick before the frame-start edge; ends one tick before the next.
   task automatic run_frame_a(input int f, input int md, input bit sc,
                              input bit mid, input int mid_md);
      mode_a   = 2'(md);
      scroll_a = sc;
      push_frame_a(f, md, sc, 128);
      for (int i = 1; i <= 350; i++) begin
         tick();
         if (mid && i == 100) mode_a = 2'(mid_md);
      end
   endtask

   task automatic check_reset_a();
      chk("rst_a hs", hs_a, 32'd1);
      chk("rst_a vs", vs_a, 32'd1);
      chk("rst_a de", de_a, 32'd0);
      chk("rst_a sof", sof_a, 32'd0);
      chk("rst_a rgb", {r_a, g_a, b_a}, 32'd0);
      chk("rst_a xy", {x_a, y_a}, 32'd0);
      chk("rst_a frame_cnt", fc_a, 32'd0);
   endtask

   task automatic check_reset_b();
      chk("rst_b hs", hs_b, 32'd0);
      chk("rst_b vs", vs_b, 32'd0);
      chk("rst_b de", de_b, 32'd0);
      chk("rst_b sof", sof_b, 32'd0);
      chk("rst_b rgb", {r_b, g_b, b_b}, 32'd0);
      chk("rst_b xy", {x_b, y_b}, 32'd0);
      chk("rst_b frame_cnt", fc_b, 32'd0);
   endtask

   // dut_a monitor: scoreboard pops, idle checks and sync/de timing.
   initial begin
      forever begin
         @(negedge clk);
         cyc_a++;
         if (rst_a) begin
            last_x = 8'd0;
            last_y = 8'd0;
         end
         if (de_a) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL pix_a: unexpected de at x=%0d y=%0d", x_a, y_a);
            end else begin
               ea = qa.pop_front();
               aa = '{x: 12'(x_a), y: 12'(y_a), rgb: {r_a, g_a, b_a}, sof: sof_a, fc: fc_a};
               if (aa !== ea) begin
                  errors++;
                  $display("FAIL pix_a: got x=%0d y=%0d rgb=%h sof=%b fc=%0d, expected x=%0d y=%0d rgb=%h sof=%b fc=%0d",
                           aa.x, aa.y, aa.rgb, aa.sof, aa.fc, ea.x, ea.y, ea.rgb, ea.sof, ea.fc);
               end
            end
            last_x = x_a;
            last_y = y_a;
         end else begin
            checks++;
            if ({r_a, g_a, b_a} !== 24'h0 || sof_a !== 1'b0 || x_a !== last_x || y_a !== last_y) begin
               errors++;
               $display("FAIL idle_a: got rgb=%h sof=%b x=%0d y=%0d, expected rgb=0 sof=0 x=%0d y=%0d",
                        {r_a, g_a, b_a}, sof_a, x_a, y_a, last_x, last_y);
            end
         end
         if (tim_en) begin
            if (hs_prev && !hs_a) begin
               if (hs_seen) chk("hs period", cyc_a - hs_fall, 32'd25);
               hs_fall = cyc_a;
               hs_seen = 1'b1;
            end else if (!hs_prev && hs_a && hs_seen) begin
               chk("hs low width", cyc_a - hs_fall, 32'd3);
            end
            if (vs_prev && !vs_a) begin
               vs_fall = cyc_a;
               vs_seen = 1'b1;
            end else if (!vs_prev && vs_a && vs_seen) begin
               chk("vs low width", cyc_a - vs_fall, 32'd50);
            end
            if (sof_a) begin
               if (sof_seen) chk("de per frame", de_cnt, 32'd128);
               de_cnt   = 0;
               sof_seen = 1'b1;
            end
            if (de_a) de_cnt++;
         end
         hs_prev = hs_a;
         vs_prev = vs_a;
      end
   end

   // dut_b monitor: scoreboard pops on de.
   initial begin
      forever begin
         @(negedge clk);
         if (de_b) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL pix_b: unexpected de at x=%0d y=%0d", x_b, y_b);
            end else begin
               eb = qb.pop_front();
               ab = '{x: x_b, y: y_b, rgb: {r_b, g_b, b_b}, sof: sof_b, fc: fc_b};
               if (ab !== eb) begin
                  errors++;
                  $display("FAIL pix_b: got x=%0d y=%0d rgb=%h sof=%b fc=%0d, expected x=%0d y=%0d rgb=%h sof=%b fc=%0d",
                           ab.x, ab.y, ab.rgb, ab.sof, ab.fc, eb.x, eb.y, eb.rgb, eb.sof, eb.fc);
               end
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      exp_t e;
      rst_a = 1'b1; rst_b = 1'b1;
      mode_a = 2'd0; mode_b = 2'd0;
      scroll_a = 1'b0; scroll_b = 1'b0;
      solid_a = 24'h123456; solid_b = 24'h000000;
      repeat (3) tick();
      check_reset_a();
      check_reset_b();

      // dut_b: first line of 1920-wide colour bars (bar width 240)
      for (int i = 0; i < 1920; i++) begin
         e.x   = 12'(i);
         e.y   = 12'd0;
         e.rgb = exp_rgb(0, 1920, i, 0, 0, 24'h0);
         e.sof = (i == 0);
         e.fc  = 16'd1;
         qb.push_back(e);
      end
      rst_b = 1'b0;
      repeat (2200) tick();
      rst_b = 1'b1;
      tick();
      chk("qb drained", qb.size(), 32'd0);

      // dut_a: three bar frames with timing checks, then the other patterns
      rst_a  = 1'b0;
      tim_en = 1'b1;
      run_frame_a(1, 0, 1'b0, 1'b0, 0);
      run_frame_a(2, 0, 1'b0, 1'b0, 0);
      run_frame_a(3, 0, 1'b0, 1'b0, 0);
      run_frame_a(4, 2, 1'b0, 1'b0, 0);
      run_frame_a(5, 1, 1'b1, 1'b0, 0);  // offset 20 mod 16 = 4
      run_frame_a(6, 0, 1'b1, 1'b0, 0);  // offset 8: x=0 is magenta
      run_frame_a(7, 0, 1'b1, 1'b0, 0);  // offset 12
      run_frame_a(8, 0, 1'b0, 1'b1, 3);  // mode -> 3 mid-frame, stays bars
      run_frame_a(9, 3, 1'b0, 1'b0, 0);  // solid 123456

      // frame 10: reset after nine pixels of the first line
      push_frame_a(10, 3, 1'b0, 9);
      repeat (10) tick();
      tim_en = 1'b0;
      rst_a  = 1'b1;
      chk("qa drained at reset", qa.size(), 32'd0);
      repeat (3) tick();
      check_reset_a();

      // release: de and sof one clock later, frame_cnt restarts at 1, offset 4
      rst_a    = 1'b0;
      mode_a   = 2'd0;
      scroll_a = 1'b1;
      push_frame_a(1, 0, 1'b1, 128);
      @(negedge clk);
      chk("de before first edge", de_a, 32'd0);
      @(negedge clk);
      chk("first de after release", de_a, 32'd1);
      chk("sof after release", sof_a, 32'd1);
      chk("frame_cnt after release", fc_a, 32'd1);
      repeat (349) tick();
      rst_a = 1'b1;

      for (int i = 0; i < 1000 && (qa.size() != 0 || qb.size() != 0); i++) tick();
      chk("qa drained", qa.size(), 32'd0);
      chk("qb drained at end", qb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
